// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: PC next-select codes, FSM states
// and the FIFO entry layout (instruction word tagged with its PC).
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;

  typedef enum logic [1:0] {
    PC_SEL_INC    = 2'b00,
    PC_SEL_BRANCH = 2'b01,
    PC_SEL_HOLD   = 2'b10
  } pc_sel_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched instructions; flush beats push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  entry_t                 wdata,
  output entry_t                 rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (count_q != '0);

  // Pointers are PTR_W bits wide, so DEPTH being a power of two makes them wrap for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: issues one outstanding imem request at a time from pc_in, buffers
// returned words with their PC for decode, and steers the PC next-select.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic [1:0]            pc_next_sel,
  input  logic                  redirect_valid,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  fetch_state_e          state_q;
  logic [ADDR_WIDTH-1:0] inflight_pc_q;
  logic                  outstanding;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  fifo_push;
  entry_t                fifo_wdata;
  entry_t                fifo_rdata;
  logic [CNT_W:0]        occ;
  logic                  pop;
  logic                  permitted;
  logic                  rsp_take;
  logic                  req_hs;

  assign outstanding = (state_q == WAIT) || (state_q == DROP);
  assign instr_valid = ~fifo_empty & ~redirect_valid;
  assign pop         = instr_valid & instr_ready;

  // Counting the in-flight word as occupied guarantees its FIFO slot on return.
  assign occ       = {1'b0, fifo_count} + (CNT_W+1)'(outstanding);
  assign permitted = ((occ - (CNT_W+1)'(pop)) < (CNT_W+1)'(FIFO_DEPTH)) & ~redirect_valid;

  assign rsp_take       = (state_q == WAIT) & imem_rsp_valid;
  assign imem_req_valid = permitted & ((state_q == REQ) | rsp_take);
  assign imem_req_addr  = pc_in;
  assign req_hs         = imem_req_valid & imem_req_ready;

  assign pc_next_sel = redirect_valid ? PC_SEL_BRANCH :
                       req_hs         ? PC_SEL_INC    : PC_SEL_HOLD;

  assign fifo_push  = rsp_take & ~redirect_valid;
  assign fifo_wdata = {inflight_pc_q, imem_rsp_data};

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign instr_data = fifo_empty ? '0 : fifo_rdata.data;
  assign instr_pc   = fifo_empty ? '0 : fifo_rdata.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (redirect_valid) begin
      state_q <= (outstanding && !imem_rsp_valid) ? DROP : REQ;
    end else begin
      case (state_q)
        IDLE:    state_q <= REQ;
        REQ:     if (req_hs) state_q <= WAIT;
        WAIT:    if (imem_rsp_valid) state_q <= req_hs ? WAIT : REQ;
        DROP:    if (imem_rsp_valid) state_q <= REQ;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (req_hs) inflight_pc_q <= pc_in;
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: PC and instruction-memory models drive the DUT; a
// program-order scoreboard checks every instruction handed to decode.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] pc_in;
  logic [1:0]    pc_next_sel;
  logic          redirect_valid;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [DW-1:0] imem_rsp_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_in          (pc_in),
    .pc_next_sel    (pc_next_sel),
    .redirect_valid (redirect_valid),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
  );

  typedef struct { logic [31:0] addr; int rem; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  pend_t       pend[$];
  exp_t        exp_q[$];
  logic [31:0] exp_next;
  logic [31:0] pc_model;
  logic [31:0] redir_target;
  int          lat;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_pops = 0;
  logic        s_hs, s_rsp;
  logic [1:0]  s_sel;
  logic [31:0] s_addr;
  exp_t        mon_e;

  assign pc_in = pc_model;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected instruction stream in program order from the last reset/redirect.
  task automatic topup();
    exp_t e;
    while (exp_q.size() < 8) begin
      e.pc = exp_next;
      e.data = mem_word(exp_next);
      exp_q.push_back(e);
      exp_next += 32'd4;
    end
  endtask

  task automatic drive_rsp();
    if (pend.size() > 0 && pend[0].rem <= 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  // Advance one clock and update the PC / memory models from what the DUT showed.
  task automatic tick();
    pend_t p;
    @(posedge clk);
    #1;
    if (s_rsp && pend.size() > 0) void'(pend.pop_front());
    foreach (pend[i]) pend[i].rem = pend[i].rem - 1;
    if (s_hs) begin
      p.addr = s_addr;
      p.rem  = lat - 1;
      pend.push_back(p);
    end
    if (!rst_n) pc_model = 32'h0;
    else if (s_sel == 2'b01) pc_model = redir_target;
    else if (s_sel == 2'b00) pc_model = pc_model + 32'd4;
    redirect_valid = 1'b0;
    drive_rsp();
    topup();
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redir_target   = target;
    exp_q.delete();
    exp_next = target;
    topup();
  endtask

  // A still-pending response is retimed to land in the IDLE cycle after release.
  task automatic do_reset(input int n, input bit check_now);
    pend_t h;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    pc_model = 32'h0;
    exp_q.delete();
    exp_next = 32'h0;
    topup();
    if (pend.size() > 0) begin
      h = pend[0];
      h.rem = n;
      pend.delete();
      pend.push_back(h);
    end
    drive_rsp();
    if (check_now) begin
      @(negedge clk);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_sel", pc_next_sel, 2'b10);
      chk("rst_instr_pc", instr_pc, 0);
    end
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    cyc++;
    s_hs   = imem_req_valid & imem_req_ready;
    s_rsp  = imem_rsp_valid;
    s_sel  = pc_next_sel;
    s_addr = imem_req_addr;
    chk("req_addr", imem_req_addr, pc_in);
    if (redirect_valid) begin
      chk("redir_sel", pc_next_sel, 2'b01);
      chk("redir_req_valid", imem_req_valid, 0);
      chk("redir_instr_valid", instr_valid, 0);
    end else begin
      chk("sel_rule", pc_next_sel, s_hs ? 2'b00 : 2'b10);
    end
    chk("fifo_overflow", dut.fifo_push & dut.fifo_full, 0);
    if (instr_valid && instr_ready) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("instr_pc", instr_pc, mon_e.pc);
        chk("instr_data", instr_data, mon_e.data);
      end
    end
  end

  initial begin
    bit found;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    pc_model       = 32'h0;
    redir_target   = 32'h0;
    lat            = 1;
    exp_next       = 32'h0;
    topup();
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_req_valid", imem_req_valid, 0);
    chk("reset_instr_valid", instr_valid, 0);
    chk("reset_sel", pc_next_sel, 2'b10);
    chk("reset_instr_data", instr_data, 0);
    chk("reset_instr_pc", instr_pc, 0);
    do_reset(2, 1'b0);

    // Streaming: first instruction in cycle 3, then one per cycle.
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      chk("t1_instr_valid", instr_valid, (c >= 3) ? 1 : 0);
      chk("t1_sel", pc_next_sel, (c >= 1) ? 2'b00 : 2'b10);
      tick();
    end

    // Decode stall fills exactly two entries and freezes the PC at 0x8.
    do_reset(2, 1'b0);
    instr_ready = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    chk("t2_count", dut.fifo_count, 2);
    chk("t2_req_valid", imem_req_valid, 0);
    chk("t2_sel", pc_next_sel, 2'b10);
    chk("t2_pc_hold", pc_in, 32'h8);
    tick();
    instr_ready = 1'b1;
    repeat (6) tick();

    // Memory back-pressure while the request for 0x10 is presented.
    do_reset(2, 1'b0);
    found = 0;
    for (int g = 0; g < 20 && !found; g++) begin
      tick();
      found = (pc_model == 32'h10);
    end
    chk("t3_reach_0x10", found, 1);
    imem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_req_valid", imem_req_valid, 1);
      chk("t3_addr", imem_req_addr, 32'h10);
      chk("t3_sel_hold", pc_next_sel, 2'b10);
      tick();
    end
    imem_req_ready = 1'b1;
    lat = 2;
    @(negedge clk);
    chk("t3_accept_sel", pc_next_sel, 2'b00);
    chk("t3_accept_addr", imem_req_addr, 32'h10);

    // Redirect while the word for 0x14 is still in flight.
    found = 0;
    for (int g = 0; g < 10 && !found; g++) begin
      tick();
      found = (pend.size() == 1) && (pend[0].addr == 32'h14) && !imem_rsp_valid;
    end
    chk("t4_inflight_0x14", found, 1);
    do_redirect(32'h100);
    @(negedge clk);
    chk("t4_sel", pc_next_sel, 2'b01);
    tick();
    @(negedge clk);
    chk("t4_state_drop", dut.state_q, DROP);
    chk("t4_drop_no_req", imem_req_valid, 0);
    found = 0;
    for (int g = 0; g < 10 && !found; g++) begin
      tick();
      @(negedge clk);
      found = instr_valid;
    end
    chk("t4_first_valid", found, 1);
    chk("t4_first_pc", instr_pc, 32'h100);

    // Redirect in the same cycle as a response: no DROP, fetch the target next.
    lat = 1;
    found = 0;
    for (int g = 0; g < 20 && !found; g++) begin
      tick();
      found = (dut.state_q == WAIT) && imem_rsp_valid;
    end
    chk("t5_find_rsp", found, 1);
    do_redirect(32'h200);
    tick();
    @(negedge clk);
    chk("t5_state_req", dut.state_q, REQ);
    chk("t5_req_valid", imem_req_valid, 1);
    chk("t5_req_addr", imem_req_addr, 32'h200);
    repeat (6) tick();

    // Reset mid-WAIT with one buffered entry.
    found = 0;
    for (int g = 0; g < 20 && !found; g++) begin
      tick();
      found = (dut.state_q == WAIT) && (dut.fifo_count == 1);
    end
    chk("t6_find_wait", found, 1);
    do_reset(2, 1'b1);
    repeat (12) tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      tick();
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 9) < 7);
      lat            = $urandom_range(1, 3);
      if ($urandom_range(0, 39) == 0) do_redirect($urandom & 32'h0000_FFFC);
    end
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    repeat (20) tick();
    chk("delivered_many", (n_pops > 500) ? 1 : 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
